// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer-width convention, default flag thresholds and
// the fill-level computation used by both the async and sync FIFOs.
package fifo_pkg;

    // Pointers carry one extra wrap bit above the memory index.
    function automatic int unsigned ptr_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic int unsigned afull_thresh_default(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd2;
    endfunction

    localparam int unsigned AEMPTY_THRESH_DEFAULT = 2;

    // Modular difference of two pointers of width ptr_w.
    function automatic logic [31:0] fifo_level(input logic [31:0] wptr,
                                               input logic [31:0] rptr,
                                               input int unsigned ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (wptr - rptr) & mask;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM with a registered read port, shaped for iCE40 BRAM
// inference. The read register clears on rst so the FIFO output starts at 0.
module fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_q;

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= '0;
        end else if (r_en) begin
            r_data_q <= mem[r_addr];
        end
    end

    assign r_data = r_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill level, almost-full/empty and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = int'(afull_thresh_default(ADDR_WIDTH)),
    parameter int AEMPTY_THRESH = int'(AEMPTY_THRESH_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_in,
    output logic                  w_full,
    output logic                  w_afull,
    output logic                  w_overflow,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_out,
    output logic                  r_empty,
    output logic                  r_aempty,
    output logic                  r_underflow,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int PTR_W = int'(ptr_width(ADDR_WIDTH));
    typedef logic [PTR_W-1:0] ptr_t;
    localparam ptr_t AFULL_LVL  = ptr_t'(AFULL_THRESH);
    localparam ptr_t AEMPTY_LVL = ptr_t'(AEMPTY_THRESH);

    ptr_t wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
    logic w_full_q, w_full_d, w_afull_q, w_afull_d;
    logic w_overflow_q, w_overflow_d, r_underflow_q, r_underflow_d;
    logic r_empty_q, r_empty_d, r_aempty_q, r_aempty_d;
    logic wr_acc, rd_acc, mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_raddr;

    assign wr_acc = w_en & ~w_full_q;
    assign rd_acc = r_en & ~r_empty_q;

`ifdef SYNC_FIFO_FWFT_EN
    // fptr tracks words moved from the RAM into its output register; rptr
    // only advances when the consumer pops, so level counts the shown word.
    ptr_t fptr_q, fptr_d;
    logic vld_q, vld_d, fetch;

    always_comb begin
        fetch  = (wptr_q != fptr_q) && (!vld_q || rd_acc);
        fptr_d = fptr_q + ptr_t'(fetch);
        vld_d  = vld_q;
        if (fetch) begin
            vld_d = 1'b1;
        end else if (rd_acc) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fptr_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            fptr_q <= fptr_d;
            vld_q  <= vld_d;
        end
    end

    assign mem_rd_en = fetch;
    assign mem_raddr = fptr_q[ADDR_WIDTH-1:0];
`else
    assign mem_rd_en = rd_acc;
    assign mem_raddr = rptr_q[ADDR_WIDTH-1:0];
`endif

    always_comb begin
        wptr_d        = wptr_q + ptr_t'(wr_acc);
        rptr_d        = rptr_q + ptr_t'(rd_acc);
        level_d       = ptr_t'(fifo_level(32'(wptr_d), 32'(rptr_d), PTR_W));
        w_full_d      = (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]) &&
                        (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]);
        w_afull_d     = level_d >= AFULL_LVL;
        r_aempty_d    = level_d <= AEMPTY_LVL;
        w_overflow_d  = w_overflow_q | (w_en & w_full_q);
        r_underflow_d = r_underflow_q | (r_en & r_empty_q);
`ifdef SYNC_FIFO_FWFT_EN
        r_empty_d     = ~vld_d;
`else
        r_empty_d     = (wptr_d == rptr_d);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            level_q       <= '0;
            w_full_q      <= 1'b0;
            w_afull_q     <= 1'b0;
            w_overflow_q  <= 1'b0;
            r_empty_q     <= 1'b1;
            r_aempty_q    <= 1'b1;
            r_underflow_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            level_q       <= level_d;
            w_full_q      <= w_full_d;
            w_afull_q     <= w_afull_d;
            w_overflow_q  <= w_overflow_d;
            r_empty_q     <= r_empty_d;
            r_aempty_q    <= r_aempty_d;
            r_underflow_q <= r_underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .w_en  (wr_acc & ~rst),
        .w_addr(wptr_q[ADDR_WIDTH-1:0]),
        .w_data(w_in),
        .r_en  (mem_rd_en),
        .r_addr(mem_raddr),
        .r_data(r_out)
    );

    assign w_full      = w_full_q;
    assign w_afull     = w_afull_q;
    assign w_overflow  = w_overflow_q;
    assign r_empty     = r_empty_q;
    assign r_aempty    = r_aempty_q;
    assign r_underflow = r_underflow_q;
    assign level       = level_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus randomized traffic, each cycle
// compared against a queue-based model of the FIFO's observable behaviour.
module tb_sync_fifo;

    localparam int DW     = 16;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 14;
    localparam int AEMPTY = 2;

    logic          clk = 1'b0;
    logic          rst, w_en, r_en;
    logic [DW-1:0] w_in, r_out;
    logic          w_full, w_afull, w_overflow, r_empty, r_aempty, r_underflow;
    logic [AW:0]   level;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rout;
    bit            m_ovf, m_udf, m_empty;

    sync_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .w_en       (w_en),
        .w_in       (w_in),
        .w_full     (w_full),
        .w_afull    (w_afull),
        .w_overflow (w_overflow),
        .r_en       (r_en),
        .r_out      (r_out),
        .r_empty    (r_empty),
        .r_aempty   (r_aempty),
        .r_underflow(r_underflow),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rout  = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_empty = 1'b1;
    endtask

    task automatic model_edge(input bit rs, input bit we, input logic [DW-1:0] wd, input bit re);
        int            sz;
        int            n_old;
        bit            full;
        bit            racc;
        logic [DW-1:0] popped;
        if (rs) begin
            model_reset();
        end else begin
            sz   = q.size();
            full = (sz == DEPTH);
`ifdef SYNC_FIFO_FWFT_EN
            racc = re && !m_empty;
`else
            racc = re && (sz != 0);
`endif
            if (we && full) m_ovf = 1'b1;
            if (re && !racc) m_udf = 1'b1;
            if (racc) begin
                popped = q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
                m_rout = popped;
`endif
            end
            n_old = q.size();
            if (we && !full) q.push_back(wd);
`ifdef SYNC_FIFO_FWFT_EN
            // Only words already in the RAM before this edge can be shown.
            m_empty = (n_old == 0);
            if (n_old > 0) m_rout = q[0];
`else
            m_empty = (q.size() == 0);
`endif
        end
    endtask

    task automatic check_all();
        check("level",     32'(level),       32'(q.size()));
        check("r_empty",   32'(r_empty),     32'(m_empty));
        check("w_full",    32'(w_full),      32'(q.size() == DEPTH));
        check("w_afull",   32'(w_afull),     32'(q.size() >= AFULL));
        check("r_aempty",  32'(r_aempty),    32'(q.size() <= AEMPTY));
        check("overflow",  32'(w_overflow),  32'(m_ovf));
        check("underflow", 32'(r_underflow), 32'(m_udf));
        check("r_out",     32'(r_out),       32'(m_rout));
    endtask

    task automatic step(input bit rs, input bit we, input logic [DW-1:0] wd, input bit re);
        @(negedge clk);
        rst  = rs;
        w_en = we;
        w_in = wd;
        r_en = re;
        @(posedge clk);
        model_edge(rs, we, wd, re);
        #1;
        check_all();
    endtask

    logic [DW-1:0] seq4 [4] = '{16'hFEDC, 16'hBEB0, 16'hBCB0, 16'hAAB0};

    initial begin
        int pw;
        int pr;
        logic [DW-1:0] cnt;
        rst  = 1'b1;
        w_en = 1'b0;
        r_en = 1'b0;
        w_in = '0;
        model_reset();

        // Reset then idle.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);

        // Four-word ordering.
        for (int i = 0; i < 4; i++) step(0, 1, seq4[i], 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Overfill to overflow, then drain.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 17; i++) step(0, 1, DW'(16'h1000 + i), 0);
        for (int i = 0; i < 17; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Steady-state at level 8 with simultaneous traffic.
        step(1, 0, 0, 0);
        cnt = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, cnt, 0);
            cnt++;
        end
        step(0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 1, cnt, 1);
            cnt++;
        end
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

        // Underflow, and write+read on empty.
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 1, 16'h5A5A, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Reset mid-operation with a concurrent write.
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, DW'(16'h2000 + i), 0);
        step(1, 1, 16'hDEAD, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);

        // Randomized traffic with varying bias and rare resets.
        for (int blk = 0; blk < 10; blk++) begin
            pw = int'($urandom_range(10, 90));
            pr = int'($urandom_range(10, 90));
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) < pw,
                     DW'($urandom),
                     $urandom_range(0, 99) < pr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the single-domain successor to the dual-clock FIFO in the FT600 datapath. It buffers DATA_WIDTH words between producer and consumer logic running on one clock. Over the dual-clock FIFO it adds:
- a fill-level output;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- an optional first-word-fall-through read mode.

## Interface
- DATA_WIDTH, 16, word width in bits
- ADDR_WIDTH, 4, depth = 2**ADDR_WIDTH words
- AFULL_THRESH, 2**ADDR_WIDTH-2, w_afull asserted when level >= this value
- AEMPTY_THRESH, 2, r_aempty asserted when level <= this value
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- w_en  in  1  write request
- w_in  in  DATA_WIDTH  write data
- w_full  out  1  no write is accepted
- w_afull  out  1  level >= AFULL_THRESH
- w_overflow  out  1  sticky: a write arrived while w_full=1
- r_en  in  1  read request (pop)
- r_out  out  DATA_WIDTH  read data
- r_empty  out  1  no read is accepted
- r_aempty  out  1  level <= AEMPTY_THRESH
- r_underflow  out  1  sticky: a read arrived while r_empty=1
- level  out  ADDR_WIDTH+1  number of words held, 0..2**ADDR_WIDTH

## Operation
- Pointers are ADDR_WIDTH+1 bits: ADDR_WIDTH bits index memory, and the MSB is a wrap bit.
  - Empty: pointers equal.
  - Full: index bits equal, MSBs differ.
  - Pointers wrap naturally modulo 2**(ADDR_WIDTH+1).
- A write is accepted when w_en=1 and w_full=0. The word is stored at wptr and wptr increments.
- A read is accepted when r_en=1 and r_empty=0. rptr increments.
- A write while full is dropped and w_overflow sets. A read while empty is dropped and r_underflow sets.
  - Both flags clear only on rst.
- All flags are registered and reflect the state after the current edge. A write and a read on the same edge are both accepted if each is individually legal; level is unchanged.
- When full, a simultaneous read does not rescue the write: the write is dropped and the read proceeds.
- When empty, a simultaneous write is accepted and the read is dropped with underflow.
- level = wptr - rptr, using ADDR_WIDTH+1-bit modular arithmetic, and includes any word held in the FWFT output stage.
- Reset values: pointers 0, level 0, r_empty 1, r_aempty 1, w_full 0, w_afull 0, w_overflow 0, r_underflow 0, r_out 0.
- Memory contents are not reset.
- rst asserted mid-operation discards all contents on that edge; a w_en or r_en in the same cycle is ignored.

## Timing
- Write at edge N: level, r_empty, w_full, w_afull and r_aempty update after edge N.
- Standard mode: a read accepted at edge N presents data on r_out after edge N (one-cycle latency). r_out holds its value until the next accepted read.
- Back-to-back operations are sustained at one word per clock in both directions.
- Throughput at full or empty boundaries: a depth-16 FIFO accepts exactly 16 consecutive writes, then w_full=1.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - The head word is preloaded into an output register, so r_out is valid whenever r_empty=0.
  - r_en acknowledges and pops the current r_out; the next word appears after the same edge.
  - A write into an empty FIFO at edge N deasserts r_empty after edge N+1, with r_out valid at the same time.
  - level counts the preloaded word.
- Undefined: standard mode as described above; no output stage.

## Structure
- Shared package fifo_pkg holds:
  - a function computing level from two pointers;
  - the pointer-width constant convention (ADDR_WIDTH+1);
  - the default threshold expressions, reused by async_fifo and sync_fifo.
- One sub-module: fifo_mem, a simple dual-port RAM with a registered read port, shaped for iCE40 BRAM inference. sync_fifo instantiates it.
- Pointer and flag logic and the FWFT output stage live in sync_fifo.

## Test plan
- Reset, then idle → r_empty=1, r_aempty=1, w_full=0, level=0, r_out=0 for 20 cycles.
- Write 16'hFEDC, 16'hBEB0, 16'hBCB0, 16'hAAB0 on consecutive cycles, then read 4 → identical sequence on r_out.
  - Standard: 1-cycle read latency.
  - FWFT: r_empty falls 2 cycles after the first write, with r_out=16'hFEDC.
- Write 17 words into depth 16 → w_full=1 after the 16th, 17th word dropped, w_overflow=1.
  - w_afull=1 from level 14.
  - Reading 16 returns words 1..16.
- Fill to level 8, then assert w_en and r_en together for 40 cycles with incrementing data → level stays 8, pointers wrap twice, order preserved, no error flags.
- Read while empty; write and read together while empty → r_underflow=1, the written word retained, level=1.
- Fill 10 words, assert rst for one cycle with w_en=1 → level=0, r_empty=1, flags cleared, the written word discarded.
